// File: rtl/pll_drp_ctrl.sv
// DRP read-modify-write sequencer for PLL reconfiguration. The PLL is held in reset
// across a command sequence, then lock is awaited; every wait is bounded by a timeout.
module pll_drp_ctrl #(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [6:0]  cmd_addr,
    input  logic [15:0] cmd_mask,
    input  logic [15:0] cmd_data,
    input  logic        cmd_last,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY,
    input  logic        LOCKED,
    output logic        PLL_RST,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int MAX_TIMEOUT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_SAT   = '1;
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, READ, WAIT_R, WRITE, WAIT_W, NEXT, WAIT_LOCK, ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic [15:0]      mask_q;
    logic [15:0]      data_q;
    logic             last_q;

    assign cmd_ready = (state == IDLE) || (state == NEXT);

    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            wait_cnt <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            DADDR    <= '0;
            DEN      <= 1'b0;
            DWE      <= 1'b0;
            DI       <= '0;
            PLL_RST  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            done <= 1'b0;
            // Saturating wait counter; every state change below restarts it from zero.
            if (wait_cnt != CNT_SAT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            case (state)
                IDLE, NEXT: begin
                    if (cmd_valid) begin
                        DADDR    <= cmd_addr;
                        mask_q   <= cmd_mask;
                        data_q   <= cmd_data;
                        last_q   <= cmd_last;
                        DEN      <= 1'b1;
                        DWE      <= 1'b0;
                        PLL_RST  <= 1'b1;
                        busy     <= 1'b1;
                        wait_cnt <= '0;
                        state    <= READ;
                    end
                end
                READ: begin
                    DEN      <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT_R;
                end
                WAIT_R: begin
                    if (DRDY) begin
                        DI       <= (DO & mask_q) | (data_q & ~mask_q);
                        DEN      <= 1'b1;
                        DWE      <= 1'b1;
                        wait_cnt <= '0;
                        state    <= WRITE;
                    end else if (wait_cnt >= DRDY_LAST) begin
                        error    <= 1'b1;
                        PLL_RST  <= 1'b0;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ERR;
                    end
                end
                WRITE: begin
                    DEN      <= 1'b0;
                    DWE      <= 1'b0;
                    wait_cnt <= '0;
                    state    <= WAIT_W;
                end
                WAIT_W: begin
                    if (DRDY) begin
                        wait_cnt <= '0;
                        if (last_q) begin
                            PLL_RST <= 1'b0;
                            state   <= WAIT_LOCK;
                        end else begin
                            state   <= NEXT;
                        end
                    end else if (wait_cnt >= DRDY_LAST) begin
                        error    <= 1'b1;
                        PLL_RST  <= 1'b0;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ERR;
                    end
                end
                WAIT_LOCK: begin
                    if (LOCKED) begin
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= IDLE;
                    end else if (wait_cnt >= LOCK_LAST) begin
                        error    <= 1'b1;
                        busy     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ERR;
                    end
                end
                ERR: begin
                    // Terminal until RST: keeps the PLL out of reset and refuses commands.
                    error   <= 1'b1;
                    PLL_RST <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// Self-checking bench for pll_drp_ctrl: a DRP responder plus a scoreboard of expected
// DRP strobes, with one task per scenario.
module tb_pll_drp_ctrl;

    localparam int DRDY_TIMEOUT = 64;
    localparam int LOCK_TIMEOUT = 4096;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } txn_t;

    logic        DCLK = 1'b0;
    logic        RST = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [6:0]  cmd_addr = '0;
    logic [15:0] cmd_mask = '0;
    logic [15:0] cmd_data = '0;
    logic        cmd_last = 1'b0;
    logic [6:0]  DADDR;
    logic        DEN;
    logic        DWE;
    logic [15:0] DI;
    logic [15:0] DO;
    logic        DRDY;
    logic        LOCKED = 1'b0;
    logic        PLL_RST;
    logic        busy;
    logic        done;
    logic        error;

    logic        auto_drdy = 1'b0;
    logic        spur_drdy = 1'b0;
    logic [15:0] resp_do = '0;
    logic [15:0] spur_do = '0;

    assign DRDY = auto_drdy | spur_drdy;
    assign DO   = spur_drdy ? spur_do : resp_do;

    txn_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   den_count = 0;
    int   done_count = 0;
    int   last_rd_cyc = -1;
    int   last_wr_cyc = -1;
    int   resp_delay = 2;
    int   resp_cd = 0;

    logic [6:0]  seq_addr[3] = '{7'h14, 7'h15, 7'h16};
    logic [15:0] seq_mask[3] = '{16'hFF00, 16'h0000, 16'h0F0F};
    logic [15:0] seq_data[3] = '{16'h0012, 16'hBEEF, 16'hA0A0};
    logic [15:0] seq_do[3]   = '{16'h1111, 16'h5555, 16'h7E7E};

    pll_drp_ctrl #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .DCLK(DCLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_mask(cmd_mask), .cmd_data(cmd_data), .cmd_last(cmd_last),
        .DADDR(DADDR), .DEN(DEN), .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY),
        .LOCKED(LOCKED), .PLL_RST(PLL_RST), .busy(busy), .done(done), .error(error)
    );

    always #5 DCLK = ~DCLK;

    // One cycle step: responder answers DRDY resp_delay cycles after a strobe, monitor pops the scoreboard.
    task automatic tick();
        txn_t e;
        @(negedge DCLK);
        cyc++;
        auto_drdy = 1'b0;
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) auto_drdy = 1'b1;
        end
        if (!RST) begin
            if (DEN && resp_delay > 0) resp_cd = resp_delay;
            checks++;
            if (!DEN && DWE) begin
                errors++;
                $display("[TB] FAIL dwe_without_den: DWE=%b required 0 at cycle %0d", DWE, cyc);
            end
            if (DEN) begin
                den_count++;
                if (DWE) last_wr_cyc = cyc;
                else     last_rd_cyc = cyc;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_strobe: DEN=1 DWE=%b DADDR=%h, required no strobe", DWE, DADDR);
                end else begin
                    e = exp_q.pop_front();
                    if ({DWE, DADDR} !== {e.we, e.addr}) begin
                        errors++;
                        $display("[TB] FAIL strobe_kind: DWE/DADDR=%b/%h required %b/%h", DWE, DADDR, e.we, e.addr);
                    end
                    if (e.we) begin
                        checks++;
                        if ({DI, PLL_RST} !== {e.di, 1'b1}) begin
                            errors++;
                            $display("[TB] FAIL write_data: DI=%h PLL_RST=%b required DI=%h PLL_RST=1", DI, PLL_RST, e.di);
                        end
                    end
                end
            end
            if (done) done_count++;
        end
    endtask

    task automatic push_expect(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input int n_exp);
        txn_t t;
        if (n_exp > 0) begin
            t.we = 1'b0; t.addr = a; t.di = '0;
            exp_q.push_back(t);
        end
        if (n_exp > 1) begin
            t.we = 1'b1; t.addr = a; t.di = (resp_do & m) | (d & ~m);
            exp_q.push_back(t);
        end
    endtask

    task automatic send_cmd(input logic [6:0] a, input logic [15:0] m, input logic [15:0] d, input logic l, input int n_exp);
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_addr = a; cmd_mask = m; cmd_data = d; cmd_last = l;
        while (cmd_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cmd_accept: cmd_ready=%b required 1 within 200 cycles", cmd_ready);
        end
        push_expect(a, m, d, n_exp);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_pll_rst_low(input int budget);
        int n;
        n = 0;
        while (PLL_RST !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (PLL_RST !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pll_rst_release: PLL_RST=%b required 0 within %0d cycles", PLL_RST, budget);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; cmd_valid = 1'b0; LOCKED = 1'b0; spur_drdy = 1'b0;
        resp_cd = 0; auto_drdy = 1'b0; exp_q.delete();
        #3;
        checks++;
        if ({DEN, DWE, PLL_RST, busy, done, error, cmd_ready} !== 7'b0000001) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: DEN,DWE,PLL_RST,busy,done,error,cmd_ready=%b required 0000001",
                     {DEN, DWE, PLL_RST, busy, done, error, cmd_ready});
        end
        checks++;
        if ({DADDR, DI} !== 23'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus: DADDR=%h DI=%h required 00/0000", DADDR, DI);
        end
        tick();
        tick();
        RST = 1'b0;
    endtask

    task automatic test_single_rmw();
        int den0;
        int done0;
        resp_delay = 2; resp_do = 16'hA5C3; LOCKED = 1'b0;
        den0 = den_count; done0 = done_count;
        send_cmd(7'h08, 16'hF000, 16'h0041, 1'b1, 2);
        wait_pll_rst_low(100);
        checks++;
        if (exp_q.size() != 0 || den_count - den0 != 2 || {busy, done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rmw_before_lock: pending=%0d strobes=%0d busy,done=%b required 0/2/10",
                     exp_q.size(), den_count - den0, {busy, done});
        end
        tick();
        tick();
        LOCKED = 1'b1;
        tick();
        checks++;
        if ({done, DI, DADDR} !== {1'b1, 16'hA041, 7'h08}) begin
            errors++;
            $display("[TB] FAIL rmw_done: done=%b DI=%h DADDR=%h required 1/A041/08", done, DI, DADDR);
        end
        tick();
        checks++;
        if ({done, busy, cmd_ready} !== 3'b001 || done_count - done0 != 1) begin
            errors++;
            $display("[TB] FAIL rmw_done_pulse: done,busy,cmd_ready=%b pulses=%0d required 001/1",
                     {done, busy, cmd_ready}, done_count - done0);
        end
        LOCKED = 1'b0;
    endtask

    task automatic test_three_cmd();
        int den0;
        int n;
        resp_delay = 2; LOCKED = 1'b0;
        den0 = den_count;
        for (int i = 0; i < 3; i++) begin
            resp_do = seq_do[i];
            send_cmd(seq_addr[i], seq_mask[i], seq_data[i], (i == 2), 2);
            if (i < 2) begin
                n = 0;
                while (cmd_ready !== 1'b1 && n < 100) begin
                    tick();
                    n++;
                    checks++;
                    if (PLL_RST !== 1'b1) begin
                        errors++;
                        $display("[TB] FAIL seq_pll_rst: PLL_RST=%b required 1", PLL_RST);
                    end
                end
                checks++;
                if (cmd_ready !== 1'b1 || exp_q.size() != 0 || cyc - last_wr_cyc != resp_delay + 1) begin
                    errors++;
                    $display("[TB] FAIL next_entry: cmd_ready=%b pending=%0d cycles_after_write=%0d required 1/0/%0d",
                             cmd_ready, exp_q.size(), cyc - last_wr_cyc, resp_delay + 1);
                end
                repeat (5) begin
                    tick();
                    checks++;
                    if ({cmd_ready, PLL_RST, busy, DEN} !== 4'b1110) begin
                        errors++;
                        $display("[TB] FAIL next_hold: cmd_ready,PLL_RST,busy,DEN=%b required 1110",
                                 {cmd_ready, PLL_RST, busy, DEN});
                    end
                end
            end
        end
        wait_pll_rst_low(100);
        checks++;
        if (den_count - den0 != 6 || exp_q.size() != 0 || cyc - last_wr_cyc != resp_delay + 1) begin
            errors++;
            $display("[TB] FAIL seq_release: strobes=%0d pending=%0d cycles_after_write=%0d required 6/0/%0d",
                     den_count - den0, exp_q.size(), cyc - last_wr_cyc, resp_delay + 1);
        end
        LOCKED = 1'b1;
        tick();
        checks++;
        if ({done, error} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL seq_done: done,error=%b required 10", {done, error});
        end
        LOCKED = 1'b0;
        tick();
    endtask

    task automatic test_lock_early();
        resp_delay = 2; resp_do = 16'h0F0F; LOCKED = 1'b1;
        send_cmd(7'h22, 16'hFFF0, 16'h0003, 1'b1, 2);
        while (PLL_RST === 1'b1 && cyc - last_rd_cyc < 100) begin
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("[TB] FAIL early_lock_done: done=%b required 0 before lock wait", done);
            end
            tick();
        end
        tick();
        checks++;
        if ({done, error, busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL early_lock: done,error,busy=%b required 100", {done, error, busy});
        end
        LOCKED = 1'b0;
        tick();
    endtask

    task automatic test_drdy_timeout(input int delay);
        int den0;
        int n;
        resp_delay = delay; resp_do = 16'h3C3C; LOCKED = 1'b0;
        send_cmd(7'h21, 16'h00FF, 16'h1200, 1'b1, 1);
        n = 0;
        while (error !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (error !== 1'b1 || cyc - last_rd_cyc != DRDY_TIMEOUT + 1) begin
            errors++;
            $display("[TB] FAIL drdy_timeout: error=%b cycles_after_read=%0d required 1/%0d",
                     error, cyc - last_rd_cyc, DRDY_TIMEOUT + 1);
        end
        checks++;
        if ({PLL_RST, cmd_ready, busy, DEN, done} !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL err_outputs: PLL_RST,cmd_ready,busy,DEN,done=%b required 00000",
                     {PLL_RST, cmd_ready, busy, DEN, done});
        end
        den0 = den_count;
        resp_delay = 2;
        cmd_valid = 1'b1; cmd_addr = 7'h33; cmd_last = 1'b1;
        repeat (10) tick();
        checks++;
        if (den_count != den0 || {error, cmd_ready} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL err_sticky: strobes=%0d error,cmd_ready=%b required 0/10",
                     den_count - den0, {error, cmd_ready});
        end
        cmd_valid = 1'b0;
        test_reset();
    endtask

    task automatic test_drdy_boundary();
        int den0;
        den0 = den_count;
        spur_do = 16'hFFFF;
        spur_drdy = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({busy, DEN, done, error, cmd_ready} !== 5'b00001) begin
                errors++;
                $display("[TB] FAIL spurious_drdy: busy,DEN,done,error,cmd_ready=%b required 00001",
                         {busy, DEN, done, error, cmd_ready});
            end
        end
        spur_drdy = 1'b0;
        checks++;
        if (den_count != den0 || DI !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL spurious_state: strobes=%0d DI=%h required 0/0000", den_count - den0, DI);
        end
        resp_delay = DRDY_TIMEOUT; resp_do = 16'h1234; LOCKED = 1'b0;
        send_cmd(7'h30, 16'h00FF, 16'hBE00, 1'b1, 2);
        wait_pll_rst_low(300);
        checks++;
        if (error !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drdy_at_limit: error=%b pending=%0d required 0/0", error, exp_q.size());
        end
        LOCKED = 1'b1;
        tick();
        checks++;
        if ({done, error, DI} !== {2'b10, 16'hBE34}) begin
            errors++;
            $display("[TB] FAIL drdy_at_limit_done: done,error=%b DI=%h required 10/BE34", {done, error}, DI);
        end
        LOCKED = 1'b0;
        tick();
    endtask

    task automatic test_lock_wait(input logic lock_at_limit);
        resp_delay = 2; resp_do = 16'h8001; LOCKED = 1'b0;
        send_cmd(7'h50, 16'h7FFE, 16'h0000, 1'b1, 2);
        wait_pll_rst_low(100);
        repeat (LOCK_TIMEOUT - 1) tick();
        checks++;
        if ({error, busy, done} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL lock_last_cycle: error,busy,done=%b required 010", {error, busy, done});
        end
        LOCKED = lock_at_limit;
        tick();
        checks++;
        if (lock_at_limit) begin
            if ({done, error, busy} !== 3'b100) begin
                errors++;
                $display("[TB] FAIL lock_at_limit: done,error,busy=%b required 100", {done, error, busy});
            end
        end else begin
            if ({error, done, busy, PLL_RST, cmd_ready} !== 5'b10000) begin
                errors++;
                $display("[TB] FAIL lock_timeout: error,done,busy,PLL_RST,cmd_ready=%b required 10000",
                         {error, done, busy, PLL_RST, cmd_ready});
            end
        end
        LOCKED = 1'b0;
        if (lock_at_limit) tick();
        else test_reset();
    endtask

    task automatic test_reset_mid();
        int n;
        int done0;
        resp_delay = 6; resp_do = 16'h0A0A; LOCKED = 1'b0;
        send_cmd(7'h40, 16'h00FF, 16'h5500, 1'b1, 2);
        n = 0;
        while (last_wr_cyc != cyc && n < 50) begin
            tick();
            n++;
        end
        tick();
        #2;
        RST = 1'b1;
        resp_cd = 0;
        #1;
        checks++;
        if ({DEN, DWE, PLL_RST, busy, done, error, cmd_ready} !== 7'b0000001 || {DADDR, DI} !== 23'h0) begin
            errors++;
            $display("[TB] FAIL reset_abort: ctrl=%b DADDR=%h DI=%h required 0000001/00/0000",
                     {DEN, DWE, PLL_RST, busy, done, error, cmd_ready}, DADDR, DI);
        end
        tick();
        done0 = done_count;
        cmd_valid = 1'b1; cmd_addr = 7'h41; cmd_mask = 16'h0000; cmd_data = 16'h0F0F; cmd_last = 1'b1;
        push_expect(7'h41, 16'h0000, 16'h0F0F, 2);
        RST = 1'b0;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({busy, DEN, DWE, DADDR} !== {3'b110, 7'h41}) begin
            errors++;
            $display("[TB] FAIL first_edge_accept: busy,DEN,DWE=%b DADDR=%h required 110/41", {busy, DEN, DWE}, DADDR);
        end
        LOCKED = 1'b1;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (done_count - done0 != 1 || error !== 1'b0 || DI !== 16'h0F0F) begin
            errors++;
            $display("[TB] FAIL post_reset_seq: pulses=%0d error=%b DI=%h required 1/0/0F0F", done_count - done0, error, DI);
        end
        LOCKED = 1'b0;
        tick();
    endtask

    initial begin
        #2;
        test_reset();
        test_single_rmw();
        test_three_cmd();
        test_lock_early();
        test_drdy_timeout(0);
        test_drdy_timeout(DRDY_TIMEOUT + 1);
        test_drdy_boundary();
        test_lock_wait(1'b0);
        test_lock_wait(1'b1);
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/pll_drp_ctrl.md
PLL_DRP_CTRL -- requirements
Module: pll_drp_ctrl

Interface
REQ-001 SHALL have parameter DRDY_TIMEOUT, default 64, the maximum number of DCLK cycles to wait for DRDY after a DEN strobe.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 4096, the maximum number of DCLK cycles to wait for LOCKED after the PLL reset is released.
REQ-003 SHALL have ports, listed as name direction width meaning:
- DCLK in 1: the only clock; all state changes on its rising edge.
- RST in 1: asynchronous active-high reset.
- cmd_valid in 1: command offered.
- cmd_ready out 1: command accepted when cmd_valid and cmd_ready are both high at a DCLK edge.
- cmd_addr in 7: DRP register address.
- cmd_mask in 16: mask; 1 = keep the old bit.
- cmd_data in 16: new bit values, used where cmd_mask is 0.
- cmd_last in 1: marks the final command of a reconfiguration sequence.
- DADDR out 7, DEN out 1, DWE out 1, DI out 16: DRP request toward the PLL.
- DO in 16, DRDY in 1: DRP response from the PLL.
- LOCKED in 1: PLL lock indicator.
- PLL_RST out 1: reset to the PLL.
- busy out 1: a sequence is in progress.
- done out 1: one-cycle pulse when a sequence completes.
- error out 1: sticky timeout flag.

Function
REQ-004 SHALL implement the states IDLE, READ, WAIT_R, WRITE, WAIT_W, NEXT, WAIT_LOCK and ERR.
REQ-005 cmd_ready SHALL be a decode of state: high in IDLE and NEXT only, low in all other states.
REQ-006 On acceptance of a command, the block SHALL latch addr, mask, data and last, then go to READ; PLL_RST SHALL be 1 from the following edge onward.
REQ-007 READ SHALL last exactly 1 cycle with DEN=1, DWE=0 and DADDR = latched addr, then go to WAIT_R.
REQ-008 In WAIT_R, on DRDY=1 the block SHALL register DI = (DO & mask) | (data & ~mask) and go to WRITE.
REQ-009 WRITE SHALL last exactly 1 cycle with DEN=1, DWE=1, DADDR = latched addr and DI held, then go to WAIT_W.
REQ-010 In WAIT_W, on DRDY=1 the block SHALL go to WAIT_LOCK if last=1, otherwise to NEXT.
REQ-011 In NEXT, PLL_RST SHALL stay 1; the block SHALL wait indefinitely for cmd_valid, and an accepted command SHALL go to READ.
REQ-012 On entering WAIT_LOCK, PLL_RST SHALL be 0.
REQ-013 In WAIT_LOCK, the first cycle with LOCKED=1 SHALL return the block to IDLE with done=1 for exactly 1 cycle.
REQ-014 DEN SHALL be 0 in every state other than READ and WRITE; DWE SHALL be 0 whenever DEN=0.
REQ-015 DADDR and DI SHALL hold their last values when idle.
REQ-016 DRDY SHALL be ignored outside WAIT_R and WAIT_W.
REQ-017 cmd_valid SHALL be ignored while cmd_ready=0.
REQ-018 DRDY arriving in the same cycle as a timeout expiry SHALL take priority over the timeout.
REQ-019 The wait counter SHALL clear on every state entry.
REQ-020 In WAIT_R or WAIT_W, if DRDY has not been seen after DRDY_TIMEOUT cycles, the block SHALL go to ERR.
REQ-021 In WAIT_LOCK, if LOCKED has not been seen after LOCK_TIMEOUT cycles, the block SHALL go to ERR.
REQ-022 ERR SHALL set error=1 and PLL_RST=0 and SHALL accept no commands; only RST leaves ERR.
REQ-023 busy SHALL be 1 in every state except IDLE and ERR.
REQ-024 The counter width SHALL be clog2(max(DRDY_TIMEOUT, LOCK_TIMEOUT)) + 1 bits, and the counter SHALL saturate rather than wrap.
REQ-025 LOCKED high before WAIT_LOCK is entered SHALL have no effect; in WAIT_LOCK it SHALL be sampled from the first cycle.

Reset
REQ-026 RST=1 SHALL asynchronously force state to IDLE and SHALL force DEN=0, DWE=0, DADDR=0, DI=0, PLL_RST=0, busy=0, done=0 and error=0; cmd_ready SHALL be 1.
REQ-027 RST asserted mid-sequence SHALL abort the sequence without completing any DRP transaction, and PLL_RST SHALL drop immediately.
REQ-028 The first command SHALL be accepted at the first DCLK edge after RST is deasserted.

Verification
REQ-029 Single-command RMW: cmd addr=0x08, mask=0xF000, data=0x0041, last=1, responder returns DO=0xA5C3 with DRDY 2 cycles after DEN -> one read at 0x08, then one write at 0x08 with DI=0xA041, PLL_RST high from accept until the write completes, then done pulses once after LOCKED rises.
REQ-030 Three-command sequence at 0x14, 0x15 and 0x16, with cmd_valid delayed 5 cycles between commands -> cmd_ready high only in NEXT, PLL_RST stays 1 throughout, exactly 6 DEN strobes, and PLL_RST falls only after the third write.
REQ-031 DRDY never returned -> error=1 after 64 wait cycles, PLL_RST=0, cmd_ready=0, and further cmd_valid is ignored until RST.
REQ-032 LOCKED held low -> ERR after 4096 cycles; with LOCKED rising at cycle 4095 of WAIT_LOCK -> done and no error.
REQ-033 RST pulsed while in WAIT_W -> all outputs return to reset values immediately, and a new command is accepted on the next edge.
REQ-034 Spurious DRDY in IDLE, and DRDY coinciding with the final timeout cycle -> the spurious DRDY is ignored and the coinciding DRDY completes the transaction with no error.
